// File: rtl/rle_row_decompressor_if.sv
// rle_row_decompressor_if: compressed-word input, row output and image
// status signals of the RLE row decompressor.
interface rle_row_decompressor_if #(
  parameter int ROW_BITS = 480,
  parameter int WORD_W   = 16
);
  logic                start;
  logic [WORD_W-1:0]   data;
  logic                data_valid;
  logic                data_ready;
  logic [ROW_BITS-1:0] row_out;
  logic                row_valid;
  logic                row_ready;
  logic [15:0]         row_count;
  logic                done;
  logic                overrun;

  modport master (
    output start,
    output data,
    output data_valid,
    output row_ready,
    input  data_ready,
    input  row_out,
    input  row_valid,
    input  row_count,
    input  done,
    input  overrun
  );

  modport slave (
    input  start,
    input  data,
    input  data_valid,
    input  row_ready,
    output data_ready,
    output row_out,
    output row_valid,
    output row_count,
    output done,
    output overrun
  );
endinterface

// File: rtl/rle_row_decompressor.sv
// rle_row_decompressor: expands run-length words into ROW_BITS-wide rows,
// one bit per cycle, and hands each row downstream via valid/ready.
module rle_row_decompressor #(
  parameter int ROW_BITS = 480,
  parameter int NUM_ROWS = 30,
  parameter int WORD_W   = 16
) (
  input logic clk,
  input logic rst,
  rle_row_decompressor_if.slave bus
);
  localparam int IW = $clog2(ROW_BITS);
  localparam int RW = WORD_W - 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_EXPAND = 3'd2;
  localparam logic [2:0] S_EMIT   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]          state;
  logic [RW-1:0]       run;
  logic                val;
  logic [IW-1:0]       bit_idx;
  logic [IW-1:0]       wr_idx;
  logic [ROW_BITS-1:0] row_q;
  logic [15:0]         row_cnt;
  logic                ovr;
  logic                last_bit;
  logic                last_row;
  logic                word_run;

  assign wr_idx   = IW'(ROW_BITS - 1) - bit_idx;
  assign last_bit = bit_idx == IW'(ROW_BITS - 1);
  assign last_row = row_cnt == 16'(NUM_ROWS - 1);
  assign word_run = bus.data[RW-1:0] != '0;

  assign bus.data_ready = state == S_LOAD;
  assign bus.row_valid  = state == S_EMIT;
  assign bus.done       = state == S_DONE;
  assign bus.row_out    = row_q;
  assign bus.row_count  = row_cnt;
  assign bus.overrun    = ovr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      run     <= '0;
      val     <= 1'b0;
      bit_idx <= '0;
      row_q   <= '0;
      row_cnt <= '0;
      ovr     <= 1'b0;
    end else begin
      unique case (1'b1)
        state == S_IDLE,
        state == S_DONE: begin
          if (bus.start) begin
            state   <= S_LOAD;
            bit_idx <= '0;
            row_q   <= '0;
            row_cnt <= '0;
            ovr     <= 1'b0;
          end
        end
        state == S_LOAD: begin
          // zero-length words are consumed without writing any bits
          if (bus.data_valid) begin
            val <= bus.data[WORD_W-1];
            run <= bus.data[RW-1:0];
            if (word_run) state <= S_EXPAND;
          end
        end
        state == S_EXPAND: begin
          row_q[wr_idx] <= val;
          run           <= run - RW'(1);
          if (last_bit) begin
            state <= S_EMIT;
          end else begin
            bit_idx <= bit_idx + IW'(1);
            if (run == RW'(1)) state <= S_LOAD;
          end
        end
        state == S_EMIT: begin
          if (bus.row_ready) begin
            row_cnt <= row_cnt + 16'd1;
            bit_idx <= '0;
            row_q   <= '0;
            if (last_row) begin
              // bits left in the final run have nowhere to go
              state <= S_DONE;
              ovr   <= run != '0;
              run   <= '0;
            end else if (run != '0) begin
              state <= S_EXPAND;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rle_row_decompressor.sv
// tb_rle_row_decompressor: random and directed images checked against
// a run-chunking reference model of the expected rows.
module tb_rle_row_decompressor;
  localparam int ROW_BITS = 480;
  localparam int NUM_ROWS = 30;
  localparam int WORD_W   = 16;

  typedef logic [ROW_BITS-1:0] val_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rle_row_decompressor_if #(.ROW_BITS(ROW_BITS), .WORD_W(WORD_W)) bus ();

  rle_row_decompressor #(
    .ROW_BITS(ROW_BITS),
    .NUM_ROWS(NUM_ROWS),
    .WORD_W  (WORD_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [WORD_W-1:0] words[$];
  val_t              exp_rows[$];
  int                exp_wi[$];
  bit                exp_ov;
  int                exp_cons;

  task automatic chk(input string tag, input val_t got, input val_t exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Fill rows run by run in whole chunks; stop at the last image row.
  function automatic void build_model();
    val_t cur;
    int   pos, n, take;
    bit   v, fin;
    exp_rows.delete();
    exp_wi.delete();
    exp_ov   = 1'b0;
    exp_cons = words.size();
    cur = '0;
    pos = 0;
    fin = 1'b0;
    for (int i = 0; i < words.size() && !fin; i++) begin
      v = words[i][WORD_W-1];
      n = int'(words[i][WORD_W-2:0]);
      while (n > 0 && !fin) begin
        take = (n < ROW_BITS - pos) ? n : ROW_BITS - pos;
        for (int k = 0; k < take; k++) cur[ROW_BITS-1-pos-k] = v;
        pos += take;
        n   -= take;
        if (pos == ROW_BITS) begin
          exp_rows.push_back(cur);
          exp_wi.push_back(i + 1);
          cur = '0;
          pos = 0;
          if (exp_rows.size() == NUM_ROWS) begin
            fin      = 1'b1;
            exp_ov   = n > 0;
            exp_cons = i + 1;
          end
        end
      end
    end
  endfunction

  task automatic gen_random();
    int                total, len;
    logic [WORD_W-1:0] w;
    words.delete();
    total = 0;
    while (total < ROW_BITS * NUM_ROWS + 40) begin
      case ($urandom_range(9))
        0:          len = 0;
        1, 2, 3, 4: len = $urandom_range(40, 1);
        5, 6, 7:    len = $urandom_range(700, 41);
        default:    len = $urandom_range(2500, 700);
      endcase
      w = {1'($urandom_range(1)), 15'(len)};
      words.push_back(w);
      total += len;
    end
  endtask

  task automatic run_image(input int gap_pct, input int rdy_pct,
                           input int hold_first, input bit chk_lat);
    int wi, ri, cyc, acc_cyc, seen_cyc, hold, bad;
    wi = 0; ri = 0; cyc = 0;
    acc_cyc = -1; seen_cyc = -1;
    hold = hold_first; bad = 0;
    build_model();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("start_done", val_t'(bus.done), val_t'(0));
    chk("start_rows", val_t'(bus.row_count), val_t'(0));
    chk("start_ovr", val_t'(bus.overrun), val_t'(0));
    while (!bus.done && cyc < 40000) begin
      bus.data_valid = (wi < words.size()) &&
                       ($urandom_range(99) >= gap_pct);
      bus.data = (wi < words.size()) ? words[wi] : '0;
      bus.row_ready = 1'($urandom_range(1));
      if (bus.row_valid) begin
        if (seen_cyc < 0) seen_cyc = cyc;
        if (ri >= exp_rows.size()) begin
          chk("extra_row", val_t'(ri), val_t'(exp_rows.size()));
          break;
        end
        if (hold > 0) begin
          hold--;
          bus.row_ready = 1'b0;
          if (bus.row_out !== exp_rows[ri] || bus.data_ready) bad++;
        end else begin
          bus.row_ready = $urandom_range(99) < rdy_pct;
        end
        if (bus.row_ready) begin
          chk("row_data", bus.row_out, exp_rows[ri]);
          chk("row_count", val_t'(bus.row_count), val_t'(ri));
          chk("row_words", val_t'(wi), val_t'(exp_wi[ri]));
          ri++;
        end
      end
      if (bus.data_valid && bus.data_ready) begin
        if (wi == 0) acc_cyc = cyc;
        wi++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.data_valid = 1'b0;
    bus.row_ready  = 1'b0;
    chk("img_done", val_t'(bus.done), val_t'(1));
    chk("img_rows", val_t'(ri), val_t'(NUM_ROWS));
    chk("img_count", val_t'(bus.row_count), val_t'(NUM_ROWS));
    chk("img_ovr", val_t'(bus.overrun), val_t'(exp_ov));
    chk("img_words", val_t'(wi), val_t'(exp_cons));
    chk("done_ready", val_t'(bus.data_ready), val_t'(0));
    if (hold_first > 0) chk("bp_hold", val_t'(bad), val_t'(0));
    if (chk_lat) chk("latency", val_t'(seen_cyc - acc_cyc), val_t'(482));
  endtask

  task automatic reset_mid();
    int cyc;
    cyc = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start      = 1'b0;
    bus.row_ready  = 1'b1;
    bus.data_valid = 1'b1;
    bus.data       = 16'h81E0;
    while (bus.row_count != 16'd3 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (100) @(negedge clk);
    chk("pre_rst_rows", val_t'(bus.row_count), val_t'(3));
    #2 rst = 1'b1;
    #1;
    chk("rst_row_out", bus.row_out, val_t'(0));
    chk("rst_row_valid", val_t'(bus.row_valid), val_t'(0));
    chk("rst_data_ready", val_t'(bus.data_ready), val_t'(0));
    chk("rst_row_count", val_t'(bus.row_count), val_t'(0));
    chk("rst_done", val_t'(bus.done), val_t'(0));
    chk("rst_overrun", val_t'(bus.overrun), val_t'(0));
    @(negedge clk);
    rst            = 1'b0;
    bus.data_valid = 1'b0;
    bus.row_ready  = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_ready", val_t'(bus.data_ready), val_t'(0));
    chk("idle_valid", val_t'(bus.row_valid), val_t'(0));
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.data       = '0;
    bus.data_valid = 1'b0;
    bus.row_ready  = 1'b0;
    repeat (2) @(negedge clk);
    chk("por_row_out", bus.row_out, val_t'(0));
    chk("por_valid", val_t'(bus.row_valid), val_t'(0));
    chk("por_ready", val_t'(bus.data_ready), val_t'(0));
    chk("por_count", val_t'(bus.row_count), val_t'(0));
    chk("por_done", val_t'(bus.done), val_t'(0));
    chk("por_ovr", val_t'(bus.overrun), val_t'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("idle_no_ready", val_t'(bus.data_ready), val_t'(0));

    reset_mid();

    words.delete();
    words.push_back(16'h80F0);
    words.push_back(16'h00F0);
    words.push_back(16'h83C0);
    words.push_back(16'h0000);
    repeat (NUM_ROWS - 3) words.push_back(16'h81E0);
    run_image(0, 100, 20, 1'b1);

    words.delete();
    repeat (NUM_ROWS - 1) words.push_back(16'h81E0);
    words.push_back(16'h81F0);
    run_image(10, 60, 0, 1'b0);

    gen_random();
    run_image(25, 75, 0, 1'b0);
    gen_random();
    run_image(5, 50, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rle_row_decompressor.md
Name: rle_row_decompressor

Overview:
- Sits between the cpu-side 16-bit data bus and the CNN image row loader.
- Expands run-length-encoded 16-bit words into fixed-width binary image rows.
- Hands each completed row downstream through a valid/ready handshake.
- Raises done after the last row of the image has been accepted.

Parameters:
- ROW_BITS, 480, bits per reconstructed image row.
- NUM_ROWS, 30, rows per image.
- WORD_W, 16, compressed word width: bit WORD_W-1 is the pixel value, bits WORD_W-2:0 are the run length.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse that begins decompression of a new image.
- data  in  WORD_W  compressed word.
- data_valid  in  1  data holds a valid word.
- data_ready  out  1  block accepts data this cycle.
- row_out  out  ROW_BITS  reconstructed row; first decoded bit is at ROW_BITS-1.
- row_valid  out  1  row_out is complete and stable.
- row_ready  in  1  downstream accepts row_out.
- row_count  out  16  rows accepted in the current image.
- done  out  1  all NUM_ROWS rows have been accepted.
- overrun  out  1  a run was still pending when the last row completed.

Behaviour:
- Reset (async, rst=1): state=IDLE; row_out=0, row_valid=0, data_ready=0, row_count=0, done=0, overrun=0; internal run counter and bit index cleared.
- States: IDLE, LOAD, EXPAND, EMIT, DONE.
- IDLE:
  - start=1 -> LOAD.
  - On entry to LOAD: clear row_count, bit_idx, row_out and overrun.
- LOAD:
  - data_ready=1 (combinational from state).
  - On data_valid=1: latch val=data[WORD_W-1] and run=data[WORD_W-2:0].
  - run==0: word is consumed, no bits are written, stay in LOAD.
  - run>0: go to EXPAND.
- EXPAND:
  - data_ready=0.
  - Each cycle: write val to row_out[ROW_BITS-1-bit_idx], bit_idx++, run--. Exactly one bit per cycle.
  - If this write lands at bit_idx==ROW_BITS-1: go to EMIT. Any remaining run is kept.
  - Else if run becomes 0: go to LOAD.
  - Latency: a word with run=n spends n cycles in EXPAND.
- EMIT:
  - row_valid=1; row_out is held stable until the transfer.
  - Transfer happens on row_valid&row_ready. On transfer: row_count++, bit_idx=0, row_out cleared the next cycle.
  - If the new row_count==NUM_ROWS: go to DONE. If run!=0 at that point, set overrun=1 and discard the remaining run.
  - Else if remaining run>0: go to EXPAND, continuing the run into the next row.
  - Else: go to LOAD.
  - row_ready while row_valid=0 is ignored.
- DONE:
  - done=1 and row_count=NUM_ROWS are held.
  - start=1 -> clear done, row_count and overrun, then go to LOAD.
- start is ignored in LOAD, EXPAND and EMIT.
- Runs spanning row boundaries are legal and span any number of rows.
- Max run is 2^(WORD_W-1)-1. The run counter is WORD_W-1 bits wide and never underflows, because the run==0 check precedes any decrement.
- bit_idx is ceil(log2(ROW_BITS)) bits wide and wraps only through the EMIT clear.
- rst asserted mid-image aborts immediately to the reset values. The partial row is lost and no row_valid is produced.

Test Plan:
- Reset: assert rst during EXPAND of row 3 -> all outputs 0 in the same cycle; state IDLE; data_ready=0 after release.
- Single-row fill: start; words 0x80F0 (1×240) then 0x00F0 (0×240) -> row_valid after 482 cycles from first accept; row_out = 240 ones then 240 zeros, MSB first; row_count=1 after row_ready.
- Spanning run: words 0x83C0 (1×960) then 0x0000 -> two consecutive rows of all ones; no data_ready between them; zero-length word consumed with no bits written.
- Backpressure: hold row_ready=0 for 20 cycles in EMIT -> row_valid stays 1, row_out unchanged, data_ready=0; row_ready=1 -> single transfer, row_count increments by exactly 1.
- Full image: NUM_ROWS=30; 30 words of 0x81E0 (1×480) -> done=1 after the 30th accept, row_count=30; start again clears done and restarts at row 0.
- Overrun: last word 0x81F0 (1×496) for row 30 -> row 30 is all ones, overrun=1, remaining 16 bits dropped, done=1.
